// File: rtl/cpu_debug_pkg.sv
// -----------------------------------------------------------------------------
// cpu_debug_pkg
//
// Purpose : Shared defaults for the CPU debug command synchroniser slice.
//           It holds the default register widths, the action-bit position,
//           the counter width, and the helper that turns an instruction-
//           register width into the number of command channels.
//
// Contents:
//   DEF_DR_W          default debug data register width (38)
//   DEF_IR_W          default instruction register width (2)
//   DEF_ACT_BIT       default sr bit selecting action / no-action (34)
//   DEF_CNT_W         default per-channel accept counter width (16)
//   DEF_SYNC_STAGES   default synchroniser depth (2)
//   num_cmd()         number of command channels for a given IR width
// -----------------------------------------------------------------------------
package cpu_debug_pkg;

  localparam int DEF_DR_W        = 38;
  localparam int DEF_IR_W        = 2;
  localparam int DEF_ACT_BIT     = 34;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Every instruction value owns one command channel.
  function automatic int num_cmd(input int ir_w);
    return 1 << ir_w;
  endfunction

endpackage : cpu_debug_pkg

// File: rtl/cpu_debug_sync_edge.sv
// -----------------------------------------------------------------------------
// cpu_debug_sync_edge
//
// Purpose : Brings one level signal from the TCK domain into the clk domain
//           through a SYNC_STAGES-deep flop chain, keeps one history flop of
//           the synchronised level, and flags rising edges for one clk cycle.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   async_i   in   level from the foreign clock domain
//   rise_o    out  one-cycle pulse on a synchronised rising edge
//
// A level that is already high when reset is released must not be reported
// as an edge. After reset both the chain and the history flop read 0, so a
// high input would look like a rise once it reaches the end of the chain.
// A small arming shift register blocks edge reporting until the history
// flop holds a genuine post-reset sample (SYNC_STAGES+1 clocks).
// -----------------------------------------------------------------------------
module cpu_debug_sync_edge
  import cpu_debug_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SYNC_STAGES:0]   arm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // arm_q[SYNC_STAGES] goes high exactly when hist_q first holds a sample
  // taken after reset release.
  assign rise_o = arm_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule : cpu_debug_sync_edge

// File: rtl/cpu_debug_cmd_sync.sv
// -----------------------------------------------------------------------------
// cpu_debug_cmd_sync
//
// Purpose : Converts JTAG update-DR / update-IR strobes into clk-domain debug
//           commands. A synchronised update-DR rise captures the shift
//           register and instruction, and presents a one-hot command on either
//           cmd_action or cmd_no_action (chosen by sr[ACT_BIT]) until the
//           consumer accepts it. Commands that arrive while one is still held
//           and not being accepted are dropped and flagged on cmd_ovf.
//
// Parameters:
//   DR_W, IR_W, SYNC_STAGES (2..4), ACT_BIT (0..DR_W-1), CNT_W
//
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   vs_udr         in   update-DR level (TCK domain)
//   vs_uir         in   update-IR level (TCK domain)
//   ir_in          in   JTAG instruction
//   sr             in   JTAG shift register
//   cmd_ready      in   consumer accepts the held command
//   ovf_clr        in   clears cmd_ovf
//   jdo            out  captured sr
//   ir_q           out  captured ir_in
//   cmd_valid      out  a command is held
//   cmd_action     out  one-hot held command, sr[ACT_BIT]=1
//   cmd_no_action  out  one-hot held command, sr[ACT_BIT]=0
//   cmd_ovf        out  sticky command-dropped flag
//   cmd_cnt        out  per-channel accept counters, channel k at [k*CNT_W +: CNT_W]
//
// Build option:
//   DEBUG_CMD_CNT_EN  when defined, saturating accept counters per channel are
//                     built; otherwise cmd_cnt is constant zero with no flops.
// -----------------------------------------------------------------------------
module cpu_debug_cmd_sync
  import cpu_debug_pkg::*;
#(
  parameter  int DR_W        = DEF_DR_W,
  parameter  int IR_W        = DEF_IR_W,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int ACT_BIT     = DEF_ACT_BIT,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int NUM_CMD     = num_cmd(IR_W)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [DR_W-1:0]          sr,
  input  logic                     cmd_ready,
  input  logic                     ovf_clr,
  output logic [DR_W-1:0]          jdo,
  output logic [IR_W-1:0]          ir_q,
  output logic                     cmd_valid,
  output logic [NUM_CMD-1:0]       cmd_action,
  output logic [NUM_CMD-1:0]       cmd_no_action,
  output logic                     cmd_ovf,
  output logic [NUM_CMD*CNT_W-1:0] cmd_cnt
);

  // ---------------------------------------------------------------------------
  // Strobe synchronisation
  // ---------------------------------------------------------------------------
  logic udr_rise;
  logic uir_rise;

  cpu_debug_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_udr_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (vs_udr),
    .rise_o  (udr_rise)
  );

  cpu_debug_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_uir_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (vs_uir),
    .rise_o  (uir_rise)
  );

  // ---------------------------------------------------------------------------
  // Command holding register
  // ---------------------------------------------------------------------------
  logic [DR_W-1:0]    jdo_q,    jdo_d;
  logic [IR_W-1:0]    ir_cap_q, ir_cap_d;
  logic               valid_q,  valid_d;
  logic [NUM_CMD-1:0] act_q,    act_d;
  logic [NUM_CMD-1:0] noact_q,  noact_d;
  logic               ovf_q,    ovf_d;

  logic               accept;
  logic               load;
  logic               drop;
  logic [NUM_CMD-1:0] chan_sel;

  // A new command may be taken when the slot is empty or is being freed in
  // this very cycle; otherwise it is lost and recorded as an overflow.
  assign accept   = valid_q & cmd_ready;
  assign load     = udr_rise & (~valid_q | cmd_ready);
  assign drop     = udr_rise & valid_q & ~cmd_ready;
  assign chan_sel = NUM_CMD'(1) << ir_in;

  always_comb begin
    jdo_d    = jdo_q;
    ir_cap_d = ir_cap_q;
    valid_d  = valid_q;
    act_d    = act_q;
    noact_d  = noact_q;
    ovf_d    = ovf_q;

    if (load) begin
      jdo_d    = sr;
      ir_cap_d = ir_in;
      valid_d  = 1'b1;
      act_d    = sr[ACT_BIT] ? chan_sel : '0;
      noact_d  = sr[ACT_BIT] ? '0 : chan_sel;
    end else if (accept) begin
      // jdo and ir_q stay put so the consumer can still read them.
      valid_d = 1'b0;
      act_d   = '0;
      noact_d = '0;
    end

    // update-IR only retargets ir_q; on a coincident update-DR load both
    // assignments take the same ir_in value.
    if (uir_rise) begin
      ir_cap_d = ir_in;
    end

    // A drop in the same cycle as a clear request leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo_q    <= '0;
      ir_cap_q <= '0;
      valid_q  <= 1'b0;
      act_q    <= '0;
      noact_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      jdo_q    <= jdo_d;
      ir_cap_q <= ir_cap_d;
      valid_q  <= valid_d;
      act_q    <= act_d;
      noact_q  <= noact_d;
      ovf_q    <= ovf_d;
    end
  end

  assign jdo           = jdo_q;
  assign ir_q          = ir_cap_q;
  assign cmd_valid     = valid_q;
  assign cmd_action    = act_q;
  assign cmd_no_action = noact_q;
  assign cmd_ovf       = ovf_q;

  // ---------------------------------------------------------------------------
  // Per-channel accept counters
  // ---------------------------------------------------------------------------
`ifdef DEBUG_CMD_CNT_EN
  for (genvar gi = 0; gi < NUM_CMD; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The channel is the instruction currently in ir_q at the accept, and
    // the count sticks at all-ones rather than wrapping.
    always_comb begin
      cnt_d = cnt_q;
      if (accept && (ir_cap_q == IR_W'(gi)) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cmd_cnt[gi*CNT_W +: CNT_W] = cnt_q;
  end : g_cnt
`else
  assign cmd_cnt = '0;
`endif

endmodule : cpu_debug_cmd_sync

// File: tb/tb_cpu_debug_cmd_sync.sv
// -----------------------------------------------------------------------------
// tb_cpu_debug_cmd_sync
//
// Self-checking bench for cpu_debug_cmd_sync. A reference model tracks the
// sampled strobe levels per clock and derives edges as a fixed delay of
// SYNC_STAGES+1 clocks, then applies the command rules. Table vectors and
// directed sequences add explicit constant expectations on top.
// Build with or without DEBUG_CMD_CNT_EN.
// -----------------------------------------------------------------------------
module tb_cpu_debug_cmd_sync;

  localparam int DR_W  = 38;
  localparam int IR_W  = 2;
  localparam int NC    = 4;
  localparam int S     = 2;
  localparam int ACT   = 34;
  localparam int CNT_W = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vs_udr = 1'b0;
  logic            vs_uir = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [DR_W-1:0] sr = '0;
  logic            cmd_ready = 1'b0;
  logic            ovf_clr = 1'b0;

  logic [DR_W-1:0]     jdo;
  logic [IR_W-1:0]     ir_q;
  logic                cmd_valid;
  logic [NC-1:0]       cmd_action;
  logic [NC-1:0]       cmd_no_action;
  logic                cmd_ovf;
  logic [NC*CNT_W-1:0] cmd_cnt;

  always #5 clk = ~clk;

  cpu_debug_cmd_sync #(
    .DR_W(DR_W), .IR_W(IR_W), .SYNC_STAGES(S), .ACT_BIT(ACT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .jdo(jdo), .ir_q(ir_q), .cmd_valid(cmd_valid), .cmd_action(cmd_action),
    .cmd_no_action(cmd_no_action), .cmd_ovf(cmd_ovf), .cmd_cnt(cmd_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit              udr_lv[$];
  bit              uir_lv[$];
  bit              m_valid;
  bit              m_act_flag;
  int              m_ch;
  logic [DR_W-1:0] m_jdo;
  logic [IR_W-1:0] m_ir;
  bit              m_ovf;
  int              m_cnt[NC];

  task automatic model_clear();
    udr_lv.delete();
    uir_lv.delete();
    m_valid = 0; m_act_flag = 0; m_ch = 0;
    m_jdo = '0; m_ir = '0; m_ovf = 0;
    for (int k = 0; k < NC; k++) m_cnt[k] = 0;
  endtask

  // A rise sampled at clock n-S (after a 0 at n-S-1) takes effect at clock n;
  // both samples must come from after reset release.
  function automatic bit rose(input bit q[$]);
    int n = q.size();
    if (n < S + 2) return 1'b0;
    return q[n-1-S] && !q[n-2-S];
  endfunction

  task automatic model_edge();
    bit ue, ie, acc;
    if (!reset_n) begin
      model_clear();
      return;
    end
    udr_lv.push_back(vs_udr);
    uir_lv.push_back(vs_uir);
    ue  = rose(udr_lv);
    ie  = rose(uir_lv);
    acc = m_valid && cmd_ready;
`ifdef DEBUG_CMD_CNT_EN
    if (acc && m_cnt[m_ir] < (1 << CNT_W) - 1) m_cnt[m_ir]++;
`endif
    if (ue && m_valid && !cmd_ready) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (ue && (!m_valid || cmd_ready)) begin
      m_valid = 1; m_jdo = sr; m_ir = ir_in;
      m_ch = int'(ir_in); m_act_flag = sr[ACT];
    end else if (acc) begin
      m_valid = 0;
    end
    if (ie) m_ir = ir_in;
  endtask

  function automatic logic [NC-1:0] exp_vec(input bit want_act);
    logic [NC-1:0] v = '0;
    if (m_valid && (m_act_flag == want_act)) v[m_ch] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC*CNT_W-1:0] exp_cnt();
    logic [NC*CNT_W-1:0] v = '0;
    for (int k = 0; k < NC; k++) v[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    return v;
  endfunction

  task automatic chk_all();
    chk("m_jdo",     64'(jdo),           64'(m_jdo));
    chk("m_ir_q",    64'(ir_q),          64'(m_ir));
    chk("m_valid",   64'(cmd_valid),     64'(m_valid));
    chk("m_action",  64'(cmd_action),    64'(exp_vec(1'b1)));
    chk("m_noact",   64'(cmd_no_action), 64'(exp_vec(1'b0)));
    chk("m_ovf",     64'(cmd_ovf),       64'(m_ovf));
    chk("m_cnt",     64'(cmd_cnt),       64'(exp_cnt()));
  endtask

  // One clock: inputs are stable at the rising edge, outputs checked at the
  // following falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Called at a falling edge; reset takes effect without a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_valid",  64'(cmd_valid), 64'd0);
    chk("rst_jdo",    64'(jdo),       64'd0);
    chk("rst_vec",    64'({cmd_action, cmd_no_action}), 64'd0);
    chk("rst_ovfcnt", 64'({cmd_ovf, cmd_cnt, ir_q}),    64'd0);
    idle(2);
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Table vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DR_W-1:0] sr;
    logic [IR_W-1:0] ir;
    logic [NC-1:0]   act;
    logic [NC-1:0]   noact;
  } vec_t;

  vec_t vecs[4];

  logic [NC*CNT_W-1:0] cnt_snap;

  initial begin
    vecs[0] = '{38'h04_0000_0001, 2'd2, 4'b0100, 4'b0000};
    vecs[1] = '{38'h00_0000_0000, 2'd0, 4'b0000, 4'b0001};
    vecs[2] = '{38'h3F_FFFF_FFFF, 2'd3, 4'b1000, 4'b0000};
    vecs[3] = '{38'h3B_FFFF_FFFF, 2'd1, 4'b0000, 4'b0010};

    model_clear();
    @(negedge clk);
    do_reset();
    idle(5);

    // Capture / no-action with the consumer always ready: each command is
    // visible for exactly one clock.
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sr = vecs[i].sr; ir_in = vecs[i].ir; vs_udr = 1'b1;
      idle(2);
      chk("tbl_latency", 64'(cmd_valid), 64'd0);
      step();
      chk("tbl_valid",  64'(cmd_valid),     64'd1);
      chk("tbl_jdo",    64'(jdo),           64'(vecs[i].sr));
      chk("tbl_action", 64'(cmd_action),    64'(vecs[i].act));
      chk("tbl_noact",  64'(cmd_no_action), 64'(vecs[i].noact));
      vs_udr = 1'b0;
      step();
      chk("tbl_clear",  64'({cmd_valid, cmd_action, cmd_no_action}), 64'd0);
      chk("tbl_hold",   64'({jdo, ir_q}), 64'({vecs[i].sr, vecs[i].ir}));
      idle(3);
    end

    // Overflow: first command retained, later ones dropped.
    cmd_ready = 1'b0;
    sr = 38'h04_1111_1111; ir_in = 2'd1; vs_udr = 1'b1; idle(3);
    vs_udr = 1'b0; idle(3);
    sr = 38'h00_2222_2222; ir_in = 2'd2; vs_udr = 1'b1; idle(3);
    chk("ovf_set",  64'(cmd_ovf),    64'd1);
    chk("ovf_keep", 64'(jdo),        64'h04_1111_1111);
    chk("ovf_vec",  64'(cmd_action), 64'b0010);
    vs_udr = 1'b0; idle(3);
    sr = 38'h00_3333_3333; vs_udr = 1'b1; idle(2);
    ovf_clr = 1'b1; step();
    chk("ovf_clr_vs_drop", 64'(cmd_ovf), 64'd1);
    vs_udr = 1'b0; step();
    chk("ovf_clr", 64'(cmd_ovf), 64'd0);
    ovf_clr = 1'b0; idle(2);

    // Back-to-back: new command lands in the accept cycle.
    sr = 38'h00_4444_4444; ir_in = 2'd1; vs_udr = 1'b1; idle(2);
    cmd_ready = 1'b1; step();
    chk("b2b_valid", 64'(cmd_valid),     64'd1);
    chk("b2b_jdo",   64'(jdo),           64'h00_4444_4444);
    chk("b2b_noact", 64'(cmd_no_action), 64'b0010);
    chk("b2b_ovf",   64'(cmd_ovf),       64'd0);
    cmd_ready = 1'b0; vs_udr = 1'b0; idle(3);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    chk("b2b_done", 64'(cmd_valid), 64'd0);
    idle(2);

    // update-IR alone.
    ir_in = 2'd3; vs_uir = 1'b1; idle(2);
    chk("uir_latency", 64'(ir_q), 64'd1);
    step();
    chk("uir_ir",    64'(ir_q),      64'd3);
    chk("uir_valid", 64'(cmd_valid), 64'd0);
    vs_uir = 1'b0; idle(3);

    // Coincident update-DR and update-IR.
    sr = 38'h04_5555_5555; ir_in = 2'd2; vs_udr = 1'b1; vs_uir = 1'b1; idle(3);
    chk("both_valid", 64'(cmd_valid),  64'd1);
    chk("both_ir",    64'(ir_q),       64'd2);
    chk("both_act",   64'(cmd_action), 64'b0100);
    vs_udr = 1'b0; vs_uir = 1'b0;
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0; idle(2);

    // Five accepts on channel 1 saturate a 2-bit counter.
    cmd_ready = 1'b1;
    repeat (5) begin
      sr = DR_W'({$urandom(), $urandom()}); ir_in = 2'd1; vs_udr = 1'b1; idle(3);
      vs_udr = 1'b0; idle(3);
    end
    cmd_ready = 1'b0;
    cnt_snap = cmd_cnt;
`ifdef DEBUG_CMD_CNT_EN
    chk("cnt_sat", 64'(cnt_snap[1*CNT_W +: CNT_W]), 64'd3);
`else
    chk("cnt_tied", 64'(cnt_snap), 64'd0);
`endif

    // Reset mid-command with vs_udr left high across release.
    sr = 38'h04_6666_6666; ir_in = 2'd2; vs_udr = 1'b1; idle(3);
    chk("mid_valid", 64'(cmd_valid), 64'd1);
    do_reset();
    idle(6);
    chk("no_edge_after_rst", 64'(cmd_valid), 64'd0);
    vs_udr = 1'b0; idle(3);

    // Randomised traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) vs_udr = ~vs_udr;
      if ($urandom_range(0, 5) == 0) vs_uir = ~vs_uir;
      cmd_ready = ($urandom_range(0, 2) == 0);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      sr        = DR_W'({$urandom(), $urandom()});
      ir_in     = IR_W'($urandom());
      if (c == 400) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cpu_debug_cmd_sync

// File: doc/cpu_debug_cmd_sync.md
CPU_DEBUG_CMD_SYNC -- requirements
Module: cpu_debug_cmd_sync

Interface
REQ-001 SHALL have parameter DR_W, default 38, debug data register width.
REQ-002 SHALL have parameter IR_W, default 2, instruction register width; NUM_CMD = 2**IR_W command channels.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal 2..4, synchroniser depth.
REQ-004 SHALL have parameter ACT_BIT, default 34, legal 0..DR_W-1, the sr bit selecting action or no-action.
REQ-005 SHALL have parameter CNT_W, default 16, per-channel counter width.
REQ-006 clk  in  1  single system clock; all state in this domain.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 vs_udr  in  1  update-DR level from the TCK domain, asynchronous to clk.
REQ-009 vs_uir  in  1  update-IR level from the TCK domain, asynchronous to clk.
REQ-010 ir_in  in  IR_W  JTAG instruction; quasi-static around vs_udr and vs_uir edges.
REQ-011 sr  in  DR_W  JTAG shift register; quasi-static around vs_udr edges.
REQ-012 cmd_ready  in  1  consumer accepts the held command.
REQ-013 ovf_clr  in  1  clears cmd_ovf.
REQ-014 jdo  out  DR_W  captured sr.
REQ-015 ir_q  out  IR_W  captured ir_in.
REQ-016 cmd_valid  out  1  a command is held.
REQ-017 cmd_action  out  NUM_CMD  one-hot, held command with sr[ACT_BIT]=1.
REQ-018 cmd_no_action  out  NUM_CMD  one-hot, held command with sr[ACT_BIT]=0.
REQ-019 cmd_ovf  out  1  sticky; a command was dropped.
REQ-020 cmd_cnt  out  NUM_CMD*CNT_W  accepted-command counters; channel k occupies bits [k*CNT_W +: CNT_W].

Function
REQ-021 SHALL pass vs_udr and vs_uir through SYNC_STAGES flops each, plus one history flop, and detect rising edges only.
REQ-022 Latency: a vs_udr rise SHALL assert cmd_valid exactly SYNC_STAGES+1 clk rising edges later.
REQ-023 udr edge with cmd_valid=0: SHALL capture jdo<=sr and ir_q<=ir_in, set cmd_valid, and set bit ir_in of cmd_action if sr[ACT_BIT] is 1, else of cmd_no_action.
REQ-024 cmd_action and cmd_no_action SHALL stay stable while cmd_valid=1, and SHALL be all-zero while cmd_valid=0.
REQ-025 cmd_valid=1 and cmd_ready=1: SHALL clear cmd_valid and both vectors on the next edge; jdo and ir_q hold their values.
REQ-026 udr edge with cmd_valid=1 and cmd_ready=0: SHALL drop the new command, keep the held one unchanged, and set cmd_ovf.
REQ-027 udr edge in the same cycle as cmd_valid & cmd_ready: SHALL load the new command, leaving cmd_valid at 1.
REQ-028 uir edge: SHALL update ir_q only; cmd_valid and the vectors are unaffected.
REQ-029 Simultaneous udr and uir edges: SHALL process the udr edge per REQ-023..027; ir_q takes ir_in in the same cycle.
REQ-030 ovf_clr SHALL clear cmd_ovf; an overflow in the same cycle wins (cmd_ovf=1).
REQ-031 The held command SHALL have at most one bit set across cmd_action|cmd_no_action.

Reset
REQ-032 reset_n low SHALL asynchronously clear all synchroniser, history and output flops: jdo=0, ir_q=0, cmd_valid=0, both vectors 0, cmd_ovf=0, cmd_cnt=0.
REQ-033 Reset asserted mid-command SHALL discard the held command; a vs_udr level already high at reset release SHALL NOT produce an edge.

Configuration
REQ-034 With DEBUG_CMD_CNT_EN defined: on each accept, cmd_cnt channel ir_q SHALL increment by 1, saturating at 2**CNT_W-1.
REQ-035 Without DEBUG_CMD_CNT_EN: cmd_cnt SHALL be tied to 0, and no counter flops SHALL be synthesised.

Structure
REQ-036 Package cpu_debug_pkg SHALL hold the default constants DR_W, IR_W, ACT_BIT and CNT_W, and the NUM_CMD derivation function.
REQ-037 Sub-module cpu_debug_sync_edge SHALL implement the SYNC_STAGES synchroniser and rising-edge detector; it is instantiated twice (udr, uir).

Verification
REQ-038 Directed test, capture: defaults; sr=38'h04_0000_0001, ir_in=2, raise vs_udr -> cmd_valid=1 after 3 clks, jdo=38'h04_0000_0001, cmd_action=4'b0100.
REQ-039 Directed test, no-action: sr[34]=0, ir_in=0, udr, cmd_ready=1 -> cmd_no_action=4'b0001 for 1 clk, then 0.
REQ-040 Directed test, overflow: hold cmd_ready=0, two udr pulses -> first command retained, cmd_ovf=1; ovf_clr with a third drop -> cmd_ovf stays 1.
REQ-041 Directed test, back-to-back: udr edge in the accept cycle -> cmd_valid stays 1, new jdo loaded, no overflow.
REQ-042 Directed test, uir: ir_in=3, vs_uir pulse -> ir_q=3 after 3 clks, cmd_valid stays 0.
REQ-043 Directed test, reset and counters: DEBUG_CMD_CNT_EN, CNT_W=2, five accepts on ch1 -> cnt[1]=3 (saturated); reset_n low mid-command -> all outputs 0 immediately.
